// File: rtl/led_pwm_array.sv
// N-channel LED brightness engine: per-channel sawtooth/triangle level stepping on a
// slow update tick, each level driving a registered, shadow-loaded PWM output.
module led_pwm_array #(
  parameter int CLK_FREQ = 12000000,
  parameter int TICK_HZ  = 100,
  parameter int N_CH     = 3,
  parameter int DW       = 8,
  parameter int PWM_DIV  = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         MODE,
  input  logic               CFG_WE,
  input  logic [3:0]         CFG_CH,
  input  logic [DW-1:0]      CFG_STEP,
  input  logic [DW-1:0]      CFG_LEVEL,
  output logic [N_CH-1:0]    LEDS,
  output logic               TICK,
  output logic [N_CH*DW-1:0] LEVELS
);

  localparam int TP = CLK_FREQ / TICK_HZ;
  localparam int TW = (TP > 1) ? $clog2(TP) : 1;
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DW-1:0] MAX = {DW{1'b1}};

  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] presc;
  logic [DW-1:0] pwm_cnt;
  logic          presc_wrap;
  logic          pwm_wrap;
  logic          cfg_hit;

  logic [DW-1:0] level     [N_CH];
  logic [DW-1:0] step      [N_CH];
  logic [DW-1:0] duty      [N_CH];
  logic          dir_dn    [N_CH];
  logic [DW-1:0] level_nxt [N_CH];
  logic          dir_nxt   [N_CH];

  function automatic logic [DW-1:0] reset_level(input int i);
    return DW'((i * (1 << DW)) / N_CH);
  endfunction

  function automatic logic [DW-1:0] reset_step(input int i);
    return DW'(32'd1 << i);
  endfunction

  // Triangle step with saturation at both rails; returns {dir_down, level}.
  function automatic logic [DW:0] tri_next(input logic [DW-1:0] lvl,
                                           input logic [DW-1:0] stp,
                                           input logic          dn);
    logic [DW:0] sum;
    sum = {1'b0, lvl} + {1'b0, stp};
    if (!dn) begin
      if (sum >= {1'b0, MAX}) return {1'b1, MAX};
      return {1'b0, sum[DW-1:0]};
    end
    if (lvl <= stp) return {1'b0, {DW{1'b0}}};
    return {1'b1, lvl - stp};
  endfunction

  assign TICK       = (tick_cnt == TW'(TP - 1));
  assign presc_wrap = (presc == PW'(PWM_DIV - 1));
  assign pwm_wrap   = presc_wrap && (pwm_cnt == MAX);
  assign cfg_hit    = CFG_WE && ({1'b0, CFG_CH} < 5'(N_CH));

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      level_nxt[i] = level[i];
      dir_nxt[i]   = dir_dn[i];
      if (TICK) begin
        case (MODE)
          2'b01:   level_nxt[i] = level[i] + step[i];
          2'b10:   {dir_nxt[i], level_nxt[i]} = tri_next(level[i], step[i], dir_dn[i]);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    LEVELS = '0;
    for (int i = 0; i < N_CH; i++) LEVELS[i*DW +: DW] = level[i];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt <= '0;
      presc    <= '0;
      pwm_cnt  <= '0;
      LEDS     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        level[i]  <= reset_level(i);
        step[i]   <= reset_step(i);
        duty[i]   <= '0;
        dir_dn[i] <= 1'b0;
      end
    end else begin
      tick_cnt <= TICK ? '0 : tick_cnt + 1'b1;
      presc    <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap) pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        // A config write wins over the tick update for its own channel only.
        if (cfg_hit && (CFG_CH == 4'(i))) begin
          level[i]  <= CFG_LEVEL;
          step[i]   <= CFG_STEP;
          dir_dn[i] <= 1'b0;
        end else begin
          level[i]  <= level_nxt[i];
          dir_dn[i] <= dir_nxt[i];
        end
        if (pwm_wrap) duty[i] <= level[i];
        LEDS[i] <= (pwm_cnt < duty[i]) && (MODE != 2'b11);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_array.sv
// Directed bench for led_pwm_array: tick/sawtooth table, triangle bounce, PWM duty,
// glitch-free reload, config collisions, off mode and mid-run reset.
module tb_led_pwm_array;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [7:0]  cfg_step;
  logic [7:0]  cfg_level;
  logic [2:0]  leds;
  logic        tick;
  logic [23:0] levels;

  int n_total = 0;
  int n_pass  = 0;

  led_pwm_array #(
    .CLK_FREQ(1000), .TICK_HZ(100), .N_CH(3), .DW(8), .PWM_DIV(1)
  ) dut (
    .CLK(clk), .RST(rst), .MODE(mode), .CFG_WE(cfg_we), .CFG_CH(cfg_ch),
    .CFG_STEP(cfg_step), .CFG_LEVEL(cfg_level), .LEDS(leds), .TICK(tick),
    .LEVELS(levels)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  mode;
    int          cycles;
    logic [23:0] exp_lv;
    logic        exp_tick;
  } vec_t;

  vec_t vt[5];

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  task automatic stepn(input int n);
    repeat (n) step1();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [7:0] lv, input logic [7:0] st);
    cfg_ch = ch; cfg_level = lv; cfg_step = st; cfg_we = 1'b1;
    step1();
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (!tick && n < 20) begin step1(); n++; end
    if (!tick) check({name, "_tick_timeout"}, 0, 1);
  endtask

  task automatic count_led0(input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin step1(); hi += int'(leds[0]); end
  endtask

  initial begin
    int hi, hi1, hi2, n;
    logic [7:0] tri_exp[$];

    rst = 1'b1; mode = 2'b01; cfg_we = 1'b0; cfg_ch = '0; cfg_step = '0; cfg_level = '0;
    vt[0] = '{2'b01, 9,    {8'd170, 8'd85, 8'd0},   1'b1};
    vt[1] = '{2'b01, 1,    {8'd174, 8'd87, 8'd1},   1'b0};
    vt[2] = '{2'b01, 10,   {8'd178, 8'd89, 8'd2},   1'b0};
    vt[3] = '{2'b01, 9,    {8'd178, 8'd89, 8'd2},   1'b1};
    vt[4] = '{2'b01, 2531, {8'd170, 8'd85, 8'd0},   1'b0};

    stepn(2);
    check("rst_levels", 32'(levels), 32'({8'd170, 8'd85, 8'd0}));
    check("rst_leds", 32'(leds), 0);
    check("rst_tick", 32'(tick), 0);
    rst = 1'b0;

    // Sawtooth / tick cadence table
    for (int i = 0; i < 5; i++) begin
      mode = vt[i].mode;
      stepn(vt[i].cycles);
      check($sformatf("saw%0d_levels", i), 32'(levels), 32'(vt[i].exp_lv));
      check($sformatf("saw%0d_tick", i), 32'(tick), 32'(vt[i].exp_tick));
    end

    // Triangle bounce on ch2: 250 step 4
    tri_exp.push_back(8'd254);
    tri_exp.push_back(8'd255);
    for (int k = 1; k <= 63; k++) tri_exp.push_back(8'(255 - 4 * k));
    tri_exp.push_back(8'd0);
    tri_exp.push_back(8'd4);
    mode = 2'b10;
    cfg_write(4'd2, 8'd250, 8'd4);
    check("tri_cfg", 32'(levels[23:16]), 250);
    stepn(9);
    for (int k = 0; k < tri_exp.size(); k++) begin
      if (k > 0) stepn(10);
      check($sformatf("tri%0d", k), 32'(levels[23:16]), 32'(tri_exp[k]));
    end
    mode = 2'b00;

    // PWM duty
    cfg_write(4'd0, 8'd64, 8'd1);
    stepn(520);
    count_led0(256, hi);
    check("pwm_duty64", hi, 64);
    cfg_write(4'd0, 8'd0, 8'd1);
    stepn(520);
    count_led0(256, hi);
    check("pwm_duty0", hi, 0);
    cfg_write(4'd0, 8'd255, 8'd1);
    stepn(520);
    count_led0(256, hi);
    check("pwm_duty255", hi, 255);

    // Glitch-free reload: 200 -> 10 mid-period
    cfg_write(4'd0, 8'd200, 8'd1);
    stepn(520);
    n = 0;
    while (leds[0] && n < 300) begin step1(); n++; end
    while (!leds[0] && n < 600) begin step1(); n++; end
    if (!leds[0]) check("glitch_edge_timeout", 0, 1);
    hi1 = 0;
    for (int k = 0; k < 256; k++) begin
      hi1 += int'(leds[0]);
      if (k == 50) begin cfg_ch = 4'd0; cfg_level = 8'd10; cfg_step = 8'd1; cfg_we = 1'b1; end
      else cfg_we = 1'b0;
      step1();
    end
    cfg_we = 1'b0;
    hi2 = 0;
    for (int k = 0; k < 256; k++) begin hi2 += int'(leds[0]); step1(); end
    check("glitch_cur_period", hi1, 200);
    check("glitch_next_period", hi2, 10);

    // Config write colliding with a tick on ch1
    wait_tick("coll");
    mode = 2'b01;
    cfg_write(4'd1, 8'd100, 8'd0);
    check("coll_tick", 32'(levels), 32'({8'd8, 8'd100, 8'd11}));
    stepn(10);
    check("coll_frozen", 32'(levels), 32'({8'd12, 8'd100, 8'd12}));
    mode = 2'b00;
    cfg_write(4'd5, 8'd77, 8'd9);
    check("cfg_ch5_ignored", 32'(levels), 32'({8'd12, 8'd100, 8'd12}));
    mode = 2'b01;
    wait_tick("ch5");
    step1();
    check("ch5_steps_kept", 32'(levels), 32'({8'd16, 8'd100, 8'd13}));

    // Off mode
    mode = 2'b11;
    step1();
    check("off_leds_1cyc", 32'(leds), 0);
    hi = 0;
    for (int k = 0; k < 300; k++) begin step1(); hi += int'(leds != 3'b000); end
    check("off_leds_run", hi, 0);
    check("off_levels_held", 32'(levels), 32'({8'd16, 8'd100, 8'd13}));
    mode = 2'b01;
    wait_tick("resume");
    step1();
    check("resume_saw", 32'(levels), 32'({8'd20, 8'd100, 8'd14}));

    // Reset mid-run, with a config write ignored during reset
    stepn(37);
    rst = 1'b1;
    cfg_ch = 4'd0; cfg_level = 8'd99; cfg_step = 8'd7; cfg_we = 1'b1;
    step1();
    check("midrst_levels", 32'(levels), 32'({8'd170, 8'd85, 8'd0}));
    check("midrst_leds", 32'(leds), 0);
    check("midrst_tick", 32'(tick), 0);
    step1();
    check("midrst_cfg_ignored", 32'(levels), 32'({8'd170, 8'd85, 8'd0}));
    rst = 1'b0; cfg_we = 1'b0;
    stepn(10);
    check("post_rst_saw", 32'(levels), 32'({8'd174, 8'd87, 8'd1}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
